// File: rtl/sysop_ctrl.sv
// rtl/sysop_ctrl.sv - machine-mode SYSTEM instruction sequencer and trap CSR file
//
// Purpose: executes CSRRW/CSRRS/CSRRC, ECALL, EBREAK and MRET, and takes
// illegal-instruction traps. It holds mstatus (MIE/MPIE), mtvec, mscratch,
// mepc, mcause and (optionally) mtval, and returns either the old CSR value
// or a PC redirect to the pipeline.
//
// Optional feature: define SYSOP_MTVAL_EN to give mtval real storage that is
// loaded on traps. Without it, 0x343 reads zero and ignores writes.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready      request handshake; o_ready is high only in IDLE
//   i_sysop [2:0]          operation code (see SYSOP_* localparams)
//   i_csr_access [1:0]     {read_en, write_en}
//   i_invalid              decoder flagged an illegal instruction
//   i_csr_addr [11:0]      CSR address
//   i_wdata [31:0]         rs1 value or zero-extended zimm
//   i_pc [31:0]            PC of the instruction
//   o_done                 one-cycle completion pulse
//   o_rdata [31:0]         old CSR value (meaningful with o_done when read_en)
//   o_redirect             with o_done: fetch from o_redirect_pc
//   o_redirect_pc [31:0]   trap vector or mepc

module sysop_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_sysop,
    input  logic [1:0]  i_csr_access,
    input  logic        i_invalid,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_pc,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc
);

    localparam logic [2:0] SYSOP_CSRRW  = 3'd0;
    localparam logic [2:0] SYSOP_CSRRS  = 3'd1;
    localparam logic [2:0] SYSOP_CSRRC  = 3'd2;
    localparam logic [2:0] SYSOP_ECALL  = 3'd3;
    localparam logic [2:0] SYSOP_EBREAK = 3'd4;
    localparam logic [2:0] SYSOP_MRET   = 3'd5;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_TRAP,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;

    // Request latched at acceptance; inputs are ignored afterwards.
    logic [2:0]  req_sysop_q, req_sysop_d;
    logic [1:0]  req_access_q, req_access_d;
    logic        req_invalid_q, req_invalid_d;
    logic [11:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] req_pc_q, req_pc_d;

    // CSR state. mtvec/mepc keep only bits [31:2]; the low bits always read 0.
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:2] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:2] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
`ifdef SYSOP_MTVAL_EN
    logic [31:0] mtval_q, mtval_d;
`endif

    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        is_csr_op;
    logic        csr_known;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        trap_illegal;
    logic        take_trap;
    logic [31:0] trap_cause;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^req_pc_q[1:0];

    assign is_csr_op = (req_sysop_q == SYSOP_CSRRW) || (req_sysop_q == SYSOP_CSRRS) ||
                       (req_sysop_q == SYSOP_CSRRC);

    // CSR read mux; csr_known flags addresses this block implements.
    always_comb begin
        csr_known = 1'b1;
        csr_old   = 32'd0;
        case (req_addr_q)
            CSR_MSTATUS:  csr_old = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MTVEC:    csr_old = {mtvec_q, 2'b00};
            CSR_MSCRATCH: csr_old = mscratch_q;
            CSR_MEPC:     csr_old = {mepc_q, 2'b00};
            CSR_MCAUSE:   csr_old = mcause_q;
`ifdef SYSOP_MTVAL_EN
            CSR_MTVAL:    csr_old = mtval_q;
`else
            CSR_MTVAL:    csr_old = 32'd0;
`endif
            CSR_MHARTID:  csr_old = HART_ID;
            default:      csr_known = 1'b0;
        endcase
    end

    always_comb begin
        csr_new = req_wdata_q;
        case (req_sysop_q)
            SYSOP_CSRRS: csr_new = csr_old | req_wdata_q;
            SYSOP_CSRRC: csr_new = csr_old & ~req_wdata_q;
            default:     csr_new = req_wdata_q;
        endcase
    end

    // Any write to the 0xC00-0xFFF range is a read-only violation.
    assign trap_illegal = req_invalid_q ||
                          (is_csr_op && (!csr_known ||
                                         (req_access_q[0] && (req_addr_q[11:10] == 2'b11))));
    assign take_trap    = trap_illegal || (req_sysop_q == SYSOP_ECALL) ||
                          (req_sysop_q == SYSOP_EBREAK);
    assign trap_cause   = trap_illegal                  ? 32'd2 :
                          (req_sysop_q == SYSOP_EBREAK) ? 32'd3 : 32'd11;

    always_comb begin
        state_d       = state_q;
        req_sysop_d   = req_sysop_q;
        req_access_d  = req_access_q;
        req_invalid_d = req_invalid_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_pc_d      = req_pc_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
`ifdef SYSOP_MTVAL_EN
        mtval_d       = mtval_q;
`endif
        done_d        = 1'b0;
        redirect_d    = 1'b0;
        rdata_d       = rdata_q;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    req_sysop_d   = i_sysop;
                    req_access_d  = i_csr_access;
                    req_invalid_d = i_invalid;
                    req_addr_d    = i_csr_addr;
                    req_wdata_d   = i_wdata;
                    req_pc_d      = i_pc;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (take_trap) begin
                    state_d = ST_TRAP;
                end else begin
                    // done/redirect are registered, so they rise as DONE is entered.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (is_csr_op) begin
                        if (req_access_q[1]) begin
                            rdata_d = csr_old;
                        end
                        if (req_access_q[0]) begin
                            case (req_addr_q)
                                CSR_MSTATUS: begin
                                    mie_d  = csr_new[3];
                                    mpie_d = csr_new[7];
                                end
                                CSR_MTVEC:    mtvec_d    = csr_new[31:2];
                                CSR_MSCRATCH: mscratch_d = csr_new;
                                CSR_MEPC:     mepc_d     = csr_new[31:2];
                                CSR_MCAUSE:   mcause_d   = csr_new;
`ifdef SYSOP_MTVAL_EN
                                CSR_MTVAL:    mtval_d    = csr_new;
`endif
                                default: ;
                            endcase
                        end
                    end else if (req_sysop_q == SYSOP_MRET) begin
                        mie_d         = mpie_q;
                        mpie_d        = 1'b1;
                        redirect_pc_d = {mepc_q, 2'b00};
                        redirect_d    = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                mepc_d        = req_pc_q[31:2];
                mcause_d      = trap_cause;
                mpie_d        = mie_q;
                mie_d         = 1'b0;
`ifdef SYSOP_MTVAL_EN
                mtval_d       = trap_illegal ? req_wdata_q : 32'd0;
`endif
                redirect_pc_d = {mtvec_q, 2'b00};
                redirect_d    = 1'b1;
                done_d        = 1'b1;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            req_sysop_q   <= 3'd0;
            req_access_q  <= 2'd0;
            req_invalid_q <= 1'b0;
            req_addr_q    <= 12'd0;
            req_wdata_q   <= 32'd0;
            req_pc_q      <= 32'd0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC[31:2];
            mscratch_q    <= 32'd0;
            mepc_q        <= 30'd0;
            mcause_q      <= 32'd0;
`ifdef SYSOP_MTVAL_EN
            mtval_q       <= 32'd0;
`endif
            done_q        <= 1'b0;
            rdata_q       <= 32'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            req_sysop_q   <= req_sysop_d;
            req_access_q  <= req_access_d;
            req_invalid_q <= req_invalid_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_pc_q      <= req_pc_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
`ifdef SYSOP_MTVAL_EN
            mtval_q       <= mtval_d;
`endif
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_ready       = (state_q == ST_IDLE);
    assign o_done        = done_q;
    assign o_rdata       = rdata_q;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_sysop_ctrl.sv
// tb/tb_sysop_ctrl.sv - directed self-checking bench for sysop_ctrl

module tb_sysop_ctrl;

    localparam logic [2:0] OP_RW = 3'd0, OP_RS = 3'd1, OP_RC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3, OP_EBREAK = 3'd4, OP_MRET = 3'd5;
    localparam logic [31:0] T_RESET_MTVEC = 32'h0000_0A03;
    localparam logic [31:0] T_HART_ID     = 32'd7;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_sysop = 3'd0;
    logic [1:0]  i_csr_access = 2'd0;
    logic        i_invalid = 1'b0;
    logic [11:0] i_csr_addr = 12'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] i_pc = 32'd0;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    sysop_ctrl #(
        .RESET_MTVEC (T_RESET_MTVEC),
        .HART_ID     (T_HART_ID)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sysop       (i_sysop),
        .i_csr_access  (i_csr_access),
        .i_invalid     (i_invalid),
        .i_csr_addr    (i_csr_addr),
        .i_wdata       (i_wdata),
        .i_pc          (i_pc),
        .o_done        (o_done),
        .o_rdata       (o_rdata),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request starting #1 after a rising edge; returns the number of
    // rising edges from acceptance (inclusive) to the first o_done sample.
    task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] acc,
                         input logic inv, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, output int lat, output logic [31:0] rd,
                         output logic redir, output logic [31:0] rpc);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_sysop = op; i_csr_access = acc; i_invalid = inv;
        i_csr_addr = addr; i_wdata = wd; i_pc = pc; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (o_done !== 1'b1 && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        rd = o_rdata; redir = o_redirect; rpc = o_redirect_pc;
        @(posedge i_clk); #1;
        chk({tag, "_pulse"}, {31'd0, o_done}, 32'd0);
    endtask

    task automatic csr_op(input string tag, input logic [2:0] op, input logic [1:0] acc,
                          input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd);
        int lat; logic [31:0] rd; logic redir; logic [31:0] rpc;
        issue(tag, op, acc, 1'b0, addr, wd, 32'h0, lat, rd, redir, rpc);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_redir"}, {31'd0, redir}, 32'd0);
        chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    task automatic rd_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_op(tag, OP_RS, 2'b10, addr, 32'd0, exp);
    endtask

    task automatic trap_op(input string tag, input logic [2:0] op, input logic [1:0] acc,
                           input logic inv, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [31:0] exp_rpc);
        int lat; logic [31:0] rd; logic redir; logic [31:0] rpc;
        issue(tag, op, acc, inv, addr, wd, pc, lat, rd, redir, rpc);
        chk({tag, "_lat"}, lat, 32'd3);
        chk({tag, "_redir"}, {31'd0, redir}, 32'd1);
        chk({tag, "_rpc"}, rpc, exp_rpc);
    endtask

    initial begin
        int lat; logic [31:0] rd; logic redir; logic [31:0] rpc;

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_redir", {31'd0, o_redirect}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_rpc", o_redirect_pc, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        rd_csr("rst_mtvec", 12'h305, 32'h0000_0A00);
        rd_csr("rst_mstatus", 12'h300, 32'h0000_1800);

        csr_op("rw_mscratch", OP_RW, 2'b11, 12'h340, 32'hDEAD_BEEF, 32'd0);
        rd_csr("rd_mscratch", 12'h340, 32'hDEAD_BEEF);

        csr_op("rs_mie", OP_RS, 2'b11, 12'h300, 32'h8, 32'h0000_1800);
        trap_op("ecall", OP_ECALL, 2'b00, 1'b0, 12'h0, 32'h0, 32'h100, 32'h0000_0A00);
        rd_csr("ecall_mcause", 12'h342, 32'd11);
        rd_csr("ecall_mepc", 12'h341, 32'h100);
        rd_csr("ecall_mstatus", 12'h300, 32'h0000_1880);

        issue("mret", OP_MRET, 2'b00, 1'b0, 12'h0, 32'h0, 32'h0, lat, rd, redir, rpc);
        chk("mret_lat", lat, 32'd2);
        chk("mret_redir", {31'd0, redir}, 32'd1);
        chk("mret_rpc", rpc, 32'h100);
        rd_csr("mret_mstatus", 12'h300, 32'h0000_1888);

        trap_op("ro_write", OP_RW, 2'b11, 1'b0, 12'hF14, 32'h55, 32'h180, 32'h0000_0A00);
        rd_csr("ro_mcause", 12'h342, 32'd2);
        rd_csr("ro_mepc", 12'h341, 32'h180);
        rd_csr("ro_mstatus", 12'h300, 32'h0000_1880);
        rd_csr("mhartid", 12'hF14, T_HART_ID);

        trap_op("ebreak", OP_EBREAK, 2'b00, 1'b0, 12'h0, 32'h0, 32'h204, 32'h0000_0A00);
        rd_csr("ebreak_mcause", 12'h342, 32'd3);
        rd_csr("ebreak_mepc", 12'h341, 32'h204);

        csr_op("rs_mstatus", OP_RS, 2'b11, 12'h300, 32'h88, 32'h0000_1800);
        csr_op("rc_mstatus", OP_RC, 2'b11, 12'h300, 32'h80, 32'h0000_1888);
        rd_csr("rc_mstatus_rd", 12'h300, 32'h0000_1808);
        csr_op("rw_mtvec", OP_RW, 2'b11, 12'h305, 32'h0000_1237, 32'h0000_0A00);
        rd_csr("mtvec_align", 12'h305, 32'h0000_1234);
        csr_op("rw_mepc", OP_RW, 2'b11, 12'h341, 32'h0000_0303, 32'h204);
        rd_csr("mepc_align", 12'h341, 32'h300);

        trap_op("bad_addr", OP_RS, 2'b10, 1'b0, 12'h7C0, 32'h0, 32'h300, 32'h0000_1234);
        rd_csr("bad_mcause", 12'h342, 32'd2);

        // Illegal flag outranks ECALL for the cause code.
        trap_op("invalid", OP_ECALL, 2'b00, 1'b1, 12'h0, 32'h1234_5673, 32'h400, 32'h0000_1234);
        rd_csr("inv_mcause", 12'h342, 32'd2);
        rd_csr("inv_mepc", 12'h341, 32'h400);
`ifdef SYSOP_MTVAL_EN
        rd_csr("mtval_trap", 12'h343, 32'h1234_5673);
        csr_op("mtval_wr", OP_RW, 2'b11, 12'h343, 32'h0000_FFFF, 32'h1234_5673);
        rd_csr("mtval_rd", 12'h343, 32'h0000_FFFF);
`else
        rd_csr("mtval_zero", 12'h343, 32'd0);
        csr_op("mtval_wr", OP_RW, 2'b11, 12'h343, 32'h0000_FFFF, 32'd0);
        rd_csr("mtval_rd", 12'h343, 32'd0);
`endif

        // Valid held high with changing inputs while busy.
        i_sysop = OP_RW; i_csr_access = 2'b11; i_invalid = 1'b0;
        i_csr_addr = 12'h340; i_wdata = 32'h1111_1111; i_valid = 1'b1;
        @(posedge i_clk); #1;
        chk("busy_ready", {31'd0, o_ready}, 32'd0);
        i_wdata = 32'h2222_2222; i_sysop = OP_ECALL;
        lat = 1;
        while (o_done !== 1'b1 && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        chk("busy_lat", lat, 32'd2);
        chk("busy_ready_done", {31'd0, o_ready}, 32'd0);
        chk("busy_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("busy_redir", {31'd0, o_redirect}, 32'd0);
        @(posedge i_clk); #1;
        rd_csr("busy_mscratch", 12'h340, 32'h1111_1111);

        // Reset asserted while in EXEC.
        i_sysop = OP_RW; i_csr_access = 2'b11; i_csr_addr = 12'h340;
        i_wdata = 32'h0000_0099; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("rexec_ready", {31'd0, o_ready}, 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("rexec_ready_rst", {31'd0, o_ready}, 32'd1);
        chk("rexec_done", {31'd0, o_done}, 32'd0);
        chk("rexec_rdata", o_rdata, 32'd0);
        chk("rexec_rpc", o_redirect_pc, 32'd0);
        chk("rexec_redir", {31'd0, o_redirect}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        rd_csr("rexec_mscratch", 12'h340, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
